// File: rtl/pipe_mips32_pkg.sv
// Shared MIPS32 pipeline package: memory-responder FSM encoding, default
// widths, and the opcode / instruction-type constants used by the pipeline.
package pipe_mips32_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned REQ_ADDR_W = 32;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned WAIT_MAX   = 15;

  // Memory responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  // Pipeline opcodes
  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_AND  = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b000011;
  localparam logic [5:0] OP_SLT  = 6'b000100;
  localparam logic [5:0] OP_MUL  = 6'b000101;
  localparam logic [5:0] OP_LW   = 6'b001000;
  localparam logic [5:0] OP_SW   = 6'b001001;
  localparam logic [5:0] OP_ADDI = 6'b001010;
  localparam logic [5:0] OP_SUBI = 6'b001011;
  localparam logic [5:0] OP_SLTI = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ = 6'b001110;
  localparam logic [5:0] OP_HLT  = 6'b111111;

  // Instruction classes carried down the pipeline
  typedef enum logic [2:0] {
    TYPE_RR_ALU = 3'd0,
    TYPE_RM_ALU = 3'd1,
    TYPE_LOAD   = 3'd2,
    TYPE_STORE  = 3'd3,
    TYPE_BRANCH = 3'd4,
    TYPE_HALT   = 3'd5
  } instr_type_e;

endpackage

// File: rtl/mips32_mem_array.sv
// Single-port synchronous RAM, DEPTH = 2**ADDR_W words of DATA_W bits.
// Ports:
//   clk1  - clock (posedge)
//   rst   - synchronous active-high reset of the read register only
//   en    - perform an access this cycle
//   we    - write enable (with en)
//   clr   - rejected access: no write, read register forced to 0
//   addr  - word index
//   wdata - write data
//   rdata - registered read data; a write returns the new word
// Storage contents are not affected by reset.
module mips32_mem_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write port
  always_ff @(posedge clk1) begin
    if (en && we && !clr) begin
      mem[addr] <= wdata;
    end
  end

  // Read register; write-first so read-during-write yields new data
  always_ff @(posedge clk1) begin
    if (rst) begin
      rdata <= '0;
    end else if (en) begin
      if (clr) begin
        rdata <= '0;
      end else if (we) begin
        rdata <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mips32_mem_responder.sv
// Memory-side responder for the MIPS32 load/store and fetch port.
// One word-indexed read or write per request over valid/ready request and
// response channels, with WAIT_CYCLES programmable wait states.
// Build option: MIPS32_MEM_BOUNDS_EN -- when defined, addresses with any of
// req_addr[31:ADDR_W] set answer rsp_err=1, rsp_rdata=0 and never write;
// when undefined, addresses wrap modulo DEPTH and rsp_err is always 0.
// Ports:
//   clk1, rst            - clock, synchronous active-high reset
//   req_valid/req_ready  - request handshake
//   req_we               - 1 = write, 0 = read
//   req_addr             - word index
//   req_wdata            - store data
//   rsp_valid/rsp_ready  - response handshake
//   rsp_rdata            - read data (written word for writes)
//   rsp_err              - out-of-range access
module mips32_mem_responder
  import pipe_mips32_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk1,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [REQ_ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  // Counter preload: WAIT spans exactly WAIT_CYCLES cycles
  localparam int unsigned CNT_LOAD = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              oob_q, oob_d;
  logic              req_ready_d;
  logic              rsp_valid_d;
  logic              rsp_err_d;

  logic              ram_en;
  logic              ram_we;
  logic              ram_clr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  logic              req_oob;

  // Out-of-range detection on the incoming address
`ifdef MIPS32_MEM_BOUNDS_EN
  assign req_oob = |req_addr[REQ_ADDR_W-1:ADDR_W];
`else
  logic unused_addr_hi;
  assign req_oob        = 1'b0;
  assign unused_addr_hi = ^req_addr[REQ_ADDR_W-1:ADDR_W];
`endif

  // State and registered outputs
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      oob_q     <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      oob_q     <= oob_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
    end
  end

  // Next state, request latch and RAM access control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    oob_d       = oob_q;
    rsp_valid_d = rsp_valid;
    rsp_err_d   = rsp_err;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_clr     = 1'b0;
    ram_addr    = addr_q;
    ram_wdata   = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          we_d    = req_we;
          addr_d  = req_addr[ADDR_W-1:0];
          wdata_d = req_wdata;
          oob_d   = req_oob;
          if (WAIT_CYCLES == 0) begin
            // No wait states: access straight from the request bus
            ram_en      = 1'b1;
            ram_we      = req_we && !req_oob;
            ram_clr     = req_oob;
            ram_addr    = req_addr[ADDR_W-1:0];
            ram_wdata   = req_wdata;
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_oob;
            state_d     = ST_RESP;
          end else begin
            cnt_d   = CNT_W'(CNT_LOAD);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          // Access happens on the edge that raises rsp_valid
          ram_en      = 1'b1;
          ram_we      = we_q && !oob_q;
          ram_clr     = oob_q;
          rsp_valid_d = 1'b1;
          rsp_err_d   = oob_q;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  mips32_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk1  (clk1),
    .rst   (rst),
    .en    (ram_en),
    .we    (ram_we),
    .clr   (ram_clr),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (rsp_rdata)
  );

endmodule

// File: tb/tb_mips32_mem_responder.sv
module tb_mips32_mem_responder;

  logic        clk1;
  logic        rst;
  logic        sel;          // 0: WAIT_CYCLES=2 instance, 1: WAIT_CYCLES=0 instance
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        rv2, rv0, rr2, rr0;
  logic        req_ready2, req_ready0;
  logic        rsp_valid2, rsp_valid0;
  logic [31:0] rsp_rdata2, rsp_rdata0;
  logic        rsp_err2, rsp_err0;

  logic        cur_req_ready, cur_rsp_valid, cur_err;
  logic [31:0] cur_rdata;

  assign rv2 = req_valid & ~sel;
  assign rv0 = req_valid & sel;
  assign rr2 = sel ? 1'b1 : rsp_ready;
  assign rr0 = sel ? rsp_ready : 1'b1;

  assign cur_req_ready = sel ? req_ready0 : req_ready2;
  assign cur_rsp_valid = sel ? rsp_valid0 : rsp_valid2;
  assign cur_rdata     = sel ? rsp_rdata0 : rsp_rdata2;
  assign cur_err       = sel ? rsp_err0   : rsp_err2;

  mips32_mem_responder #(.DATA_W(32), .ADDR_W(10), .WAIT_CYCLES(2)) u_dut2 (
    .clk1(clk1), .rst(rst),
    .req_valid(rv2), .req_ready(req_ready2), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_ready(rr2),
    .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2)
  );

  mips32_mem_responder #(.DATA_W(32), .ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk1(clk1), .rst(rst),
    .req_valid(rv0), .req_ready(req_ready0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_ready(rr0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timeout waiting on DUT", nm);
  endtask

  // Pop scoreboard and compare against the response about to handshake
  task automatic pop_cmp(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: response with empty scoreboard, got %h", nm, cur_rdata);
    end else begin
      e = sb.pop_front();
      chk({nm, " rdata"}, cur_rdata, e.rd);
      chk({nm, " err"}, {31'd0, cur_err}, {31'd0, e.err});
    end
  endtask

  // Wait (at negedges) for rsp_valid; returns negedges counted since accept
  task automatic wait_rsp(input int start, output int lat, output bit ok);
    lat = start;
    while (!cur_rsp_valid && lat < 40) begin
      @(negedge clk1);
      lat++;
    end
    ok = cur_rsp_valid;
  endtask

  // One complete transaction with latency and data checks
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input string nm);
    int  guard;
    int  lat;
    bit  ok;
    exp_t e;
    @(negedge clk1);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    guard = 0;
    while (!cur_req_ready && guard < 40) begin
      @(negedge clk1);
      guard++;
    end
    if (!cur_req_ready) begin
      timeout_fail({nm, " accept"});
      req_valid = 1'b0;
      return;
    end
    e.rd  = exp_rd;
    e.err = exp_err;
    sb.push_back(e);
    @(negedge clk1);
    req_valid = 1'b0;
    wait_rsp(1, lat, ok);
    if (!ok) begin
      timeout_fail({nm, " rsp"});
      void'(sb.pop_front());
      return;
    end
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    pop_cmp(nm);
    @(negedge clk1);
    chk({nm, " rsp_valid drop"}, {31'd0, cur_rsp_valid}, 32'd0);
  endtask

  vec_t vecs[8];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   lat;
    bit   ok;
    int   guard;
    exp_t e;

    vecs[0] = '{1'b1, 32'd5,    32'h0000_5555, 32'h0000_5555, 1'b0};
    vecs[1] = '{1'b1, 32'd10,   32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b0, 32'd10,   32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b1, 32'd0,    32'hCAFE_0000, 32'hCAFE_0000, 1'b0};
    vecs[4] = '{1'b1, 32'd1023, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0};
    vecs[5] = '{1'b0, 32'd1023, 32'h0,         32'h0BAD_F00D, 1'b0};
`ifdef MIPS32_MEM_BOUNDS_EN
    vecs[6] = '{1'b1, 32'd1024, 32'h1234_5678, 32'h0,         1'b1};
    vecs[7] = '{1'b0, 32'd0,    32'h0,         32'hCAFE_0000, 1'b0};
`else
    vecs[6] = '{1'b1, 32'd1024, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[7] = '{1'b0, 32'd0,    32'h0,         32'h1234_5678, 1'b0};
`endif

    sel = 1'b0; rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

    // Power-on reset values
    repeat (3) @(negedge clk1);
    chk("reset req_ready", {31'd0, req_ready2}, 32'd0);
    chk("reset rsp_valid", {31'd0, rsp_valid2}, 32'd0);
    chk("reset rsp_rdata", rsp_rdata2, 32'd0);
    chk("reset rsp_err",   {31'd0, rsp_err2}, 32'd0);
    rst = 1'b0;
    @(negedge clk1);
    chk("post-reset req_ready", {31'd0, req_ready2}, 32'd1);

    // Table: WAIT_CYCLES=2 instance, latency 3 each
    for (int i = 0; i < 8; i++) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rd, vecs[i].exp_err, 3, $sformatf("vec%0d", i));
    end

    // Reset in the middle of WAIT of a write to 5: write must be dropped
    @(negedge clk1);
    req_we = 1'b1; req_addr = 32'd5; req_wdata = 32'hFFFF_0000; req_valid = 1'b1;
    guard = 0;
    while (!cur_req_ready && guard < 40) begin @(negedge clk1); guard++; end
    @(negedge clk1);
    req_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk1);
    chk("midwait rst rsp_valid", {31'd0, rsp_valid2}, 32'd0);
    chk("midwait rst req_ready", {31'd0, req_ready2}, 32'd0);
    rst = 1'b0;
    @(negedge clk1);
    chk("midwait post req_ready", {31'd0, req_ready2}, 32'd1);
    chk("midwait post rsp_valid", {31'd0, rsp_valid2}, 32'd0);
    do_req(1'b0, 32'd5, 32'h0, 32'h0000_5555, 1'b0, 3, "rd5 after rst");

    // Backpressure: hold rsp_ready low for 5 cycles with a second request pending
    @(negedge clk1);
    req_we = 1'b0; req_addr = 32'd10; req_valid = 1'b1; rsp_ready = 1'b0;
    guard = 0;
    while (!cur_req_ready && guard < 40) begin @(negedge clk1); guard++; end
    e.rd = 32'hDEAD_BEEF; e.err = 1'b0;
    sb.push_back(e);
    @(negedge clk1);
    wait_rsp(1, lat, ok);
    if (!ok) timeout_fail("bp rsp");
    chk("bp latency", 32'(lat), 32'd3);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp stall%0d rsp_valid", c), {31'd0, cur_rsp_valid}, 32'd1);
      chk($sformatf("bp stall%0d rdata", c), cur_rdata, 32'hDEAD_BEEF);
      chk($sformatf("bp stall%0d req_ready", c), {31'd0, cur_req_ready}, 32'd0);
      @(negedge clk1);
    end
    rsp_ready = 1'b1;
    pop_cmp("bp first");
    @(negedge clk1);
    // Second request is accepted on the edge after the handshake
    chk("bp after hs rsp_valid", {31'd0, cur_rsp_valid}, 32'd0);
    chk("bp after hs req_ready", {31'd0, cur_req_ready}, 32'd1);
    sb.push_back(e);
    @(negedge clk1);
    req_valid = 1'b0;
    wait_rsp(1, lat, ok);
    if (!ok) timeout_fail("bp second rsp");
    chk("bp second latency", 32'(lat), 32'd3);
    pop_cmp("bp second");
    @(negedge clk1);

    // WAIT_CYCLES=0 instance: preload 0..3, then back-to-back reads
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, 32'(i), 32'hA5A5_0000 + 32'(i), 32'hA5A5_0000 + 32'(i), 1'b0, 1,
             $sformatf("w0 pre%0d", i));
    end
    begin
      int n_acc;
      int n_rsp;
      int last_cyc;
      n_acc = 0; n_rsp = 0; last_cyc = 0;
      @(negedge clk1);
      req_we = 1'b0; rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && n_rsp < 4; cyc++) begin
        req_valid = (n_acc < 4);
        req_addr  = 32'(n_acc);
        if (cur_rsp_valid) begin
          pop_cmp($sformatf("b2b rsp%0d", n_rsp));
          if (n_rsp > 0) chk($sformatf("b2b gap%0d", n_rsp), 32'(cyc - last_cyc), 32'd2);
          last_cyc = cyc;
          n_rsp++;
        end
        if (req_valid && cur_req_ready) begin
          e.rd = 32'hA5A5_0000 + 32'(n_acc); e.err = 1'b0;
          sb.push_back(e);
          n_acc++;
        end
        @(negedge clk1);
      end
      req_valid = 1'b0;
      chk("b2b response count", 32'(n_rsp), 32'd4);
    end

    @(negedge clk1);
    chk("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
